// File: rtl/scmp_busif_pkg.sv
// Shared types and constants for the SC/MP-style external bus interface.
package scmp_busif_pak;

  // Bus cycle sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAddr,
    StStrobe,
    StRecover
  } state_e;

  // Bit positions of the cycle-type flags inside flags {H,D,I,R}.
  localparam int unsigned FLAG_H = 3;
  localparam int unsigned FLAG_D = 2;
  localparam int unsigned FLAG_I = 1;
  localparam int unsigned FLAG_R = 0;

  localparam int unsigned CntWidth = 4;

  // Data bus contents during the address phase: flags on D[7:4], A[15:12] on D[3:0].
  function automatic logic [7:0] addr_phase_data(input logic [3:0] flags,
                                                 input logic [3:0] addr_hi);
    return {flags[FLAG_H], flags[FLAG_D], flags[FLAG_I], flags[FLAG_R], addr_hi};
  endfunction

endpackage

// File: rtl/scmp_busif_if.sv
// Core-side request handshake plus external bus pins of scmp_busif.
interface scmp_busif_if;

  // Core side
  logic        req_i;
  logic        we_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic [3:0]  flags_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  rdata_o;

  // External bus side
  logic [11:0] addr_o;
  logic [7:0]  D_i;
  logic [7:0]  D_o;
  logic        D_oe_o;
  logic        ADS_n;
  logic        RD_n;
  logic        WR_n;
  logic        hold_i;
  logic        breq_o;
  logic        enin_i;
  logic        enout_o;

  // Bus interface block side
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, flags_i, D_i, hold_i, enin_i,
    output busy_o, done_o, rdata_o, addr_o, D_o, D_oe_o, ADS_n, RD_n, WR_n, breq_o, enout_o
  );

  // Core / environment side
  modport master (
    output req_i, we_i, addr_i, wdata_i, flags_i, D_i, hold_i, enin_i,
    input  busy_o, done_o, rdata_o, addr_o, D_o, D_oe_o, ADS_n, RD_n, WR_n, breq_o, enout_o
  );

endinterface

// File: rtl/scmp_busif.sv
// External bus cycle sequencer: arbitration, address phase, strobe with wait/hold, recovery.
module scmp_busif
  import scmp_busif_pak::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          ARB_EN      = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  scmp_busif_if.slave  bus
);

  localparam logic [CntWidth-1:0] WaitLoad = CntWidth'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic                we_q, we_n;
  logic [15:0]         addr_q, addr_n;
  logic [7:0]          wdata_q, wdata_n;
  logic [3:0]          flags_q, flags_n;
  logic [CntWidth-1:0] cnt_q;
  logic                accept;

  // Registered outputs, computed from the next state so strobes come straight off flops.
  logic                ads_n_q, rd_n_q, wr_n_q, breq_q, done_q, d_oe_q;
  logic                ads_n_d, rd_n_d, wr_n_d, breq_d, done_d, d_oe_d;
  logic [7:0]          d_o_q, d_o_d, rdata_q;

  assign accept = (state_q == StIdle) && bus.req_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.req_i) state_d = ARB_EN ? StArb : StAddr;
      StArb:     if (bus.enin_i) state_d = StAddr;
      StAddr:    state_d = StStrobe;
      StStrobe:  if ((cnt_q == '0) && !bus.hold_i) state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Request fields as they will be after this edge (latched only on acceptance).
  always_comb begin
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    flags_n = flags_q;
    if (accept) begin
      we_n    = bus.we_i;
      addr_n  = bus.addr_i;
      wdata_n = bus.wdata_i;
      flags_n = bus.flags_i;
    end
  end

  // Output decode for the coming cycle.
  always_comb begin
    ads_n_d = (state_d != StAddr);
    rd_n_d  = !((state_d == StStrobe) && !we_n);
    wr_n_d  = !((state_d == StStrobe) && we_n);
    done_d  = (state_d == StRecover);
    breq_d  = ARB_EN && (state_d != StIdle);
    d_oe_d  = 1'b0;
    d_o_d   = 8'h00;
    if (state_d == StAddr) begin
      d_oe_d = 1'b1;
      d_o_d  = addr_phase_data(flags_n, addr_n[15:12]);
    end else if ((state_d == StStrobe) && we_n) begin
      d_oe_d = 1'b1;
      d_o_d  = wdata_n;
    end
  end

  // State, latched request and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      flags_q <= '0;
      ads_n_q <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      breq_q  <= 1'b0;
      done_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      d_o_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      flags_q <= flags_n;
      ads_n_q <= ads_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      breq_q  <= breq_d;
      done_q  <= done_d;
      d_oe_q  <= d_oe_d;
      d_o_q   <= d_o_d;
    end
  end

  // Wait counter: loaded while leaving the address phase, counts down during the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == StAddr) begin
      cnt_q <= WaitLoad;
    end else if ((state_q == StStrobe) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Read data is taken only on the edge that ends the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if ((state_q == StStrobe) && (state_d == StRecover) && !we_q) begin
      rdata_q <= bus.D_i;
    end
  end

  assign bus.busy_o  = (state_q != StIdle);
  assign bus.done_o  = done_q;
  assign bus.rdata_o = rdata_q;
  assign bus.addr_o  = addr_q[11:0];
  assign bus.D_o     = d_o_q;
  assign bus.D_oe_o  = d_oe_q;
  assign bus.ADS_n   = ads_n_q;
  assign bus.RD_n    = rd_n_q;
  assign bus.WR_n    = wr_n_q;
  assign bus.breq_o  = breq_q;
  assign bus.enout_o = bus.enin_i & ~breq_q;

endmodule

// File: tb/tb_scmp_busif.sv
// Directed bench for scmp_busif: three parameterisations share one clock and reset.
module tb_scmp_busif;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  scmp_busif_if if0 ();
  scmp_busif_if if3 ();
  scmp_busif_if ifa ();

  scmp_busif #(.WAIT_CYCLES(0), .ARB_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  scmp_busif #(.WAIT_CYCLES(3), .ARB_EN(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  scmp_busif #(.WAIT_CYCLES(0), .ARB_EN(1'b0)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa));

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  flags;
    logic [7:0]  din;
    logic [7:0]  exp_ado;
    logic [11:0] exp_addr;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full cycle on u0 (WAIT_CYCLES=0, ARB_EN=1, grant present), checked phase by phase.
  task automatic run_vec(input vec_t v);
    if0.req_i = 1'b1; if0.we_i = v.we; if0.addr_i = v.addr;
    if0.wdata_i = v.wdata; if0.flags_i = v.flags; if0.D_i = v.din;
    step(); if0.req_i = 1'b0;
    chk("arb_busy", if0.busy_o, 1'b1);
    chk("arb_breq", if0.breq_o, 1'b1);
    chk("arb_ads", if0.ADS_n, 1'b1);
    chk("arb_addr_o", if0.addr_o, v.exp_addr);
    chk("arb_enout", if0.enout_o, 1'b0);
    step();
    chk("addr_ads", if0.ADS_n, 1'b0);
    chk("addr_oe", if0.D_oe_o, 1'b1);
    chk("addr_do", if0.D_o, v.exp_ado);
    chk("addr_rdwr", {if0.RD_n, if0.WR_n}, 2'b11);
    step();
    chk("strb_rd", if0.RD_n, v.we);
    chk("strb_wr", if0.WR_n, !v.we);
    chk("strb_ads", if0.ADS_n, 1'b1);
    chk("strb_oe", if0.D_oe_o, v.we);
    chk("strb_do", if0.D_o, v.we ? v.wdata : 8'h00);
    chk("strb_done", if0.done_o, 1'b0);
    step();
    chk("rec_done", if0.done_o, 1'b1);
    chk("rec_strobes", {if0.ADS_n, if0.RD_n, if0.WR_n}, 3'b111);
    chk("rec_oe_do", {if0.D_oe_o, if0.D_o}, 9'h000);
    chk("rec_rdata", if0.rdata_o, v.exp_rdata);
    chk("rec_addr_o", if0.addr_o, v.exp_addr);
    chk("rec_busy", if0.busy_o, 1'b1);
    step();
    chk("idle_done", if0.done_o, 1'b0);
    chk("idle_busy", if0.busy_o, 1'b0);
    chk("idle_breq", if0.breq_o, 1'b0);
    chk("idle_enout", if0.enout_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int done_cnt;
    int k;
    logic [4:0] a0_pat[7];

    //          we    addr      wdata  flags   din    ado    addr_o   rdata
    vecs[0] = '{1'b0, 16'hA123, 8'h00, 4'b0001, 8'h5A, 8'h1A, 12'h123, 8'h5A};
    vecs[1] = '{1'b1, 16'h5F00, 8'h3C, 4'b1000, 8'h77, 8'h85, 12'hF00, 8'h5A};
    vecs[2] = '{1'b0, 16'h0FFF, 8'h00, 4'b0110, 8'hA5, 8'h60, 12'hFFF, 8'hA5};
    vecs[3] = '{1'b1, 16'hFFFF, 8'h00, 4'b1111, 8'hFF, 8'hFF, 12'hFFF, 8'hA5};
    vecs[4] = '{1'b0, 16'h8000, 8'h00, 4'b0000, 8'h00, 8'h08, 12'h000, 8'h00};

    // {busy, ADS_n, RD_n, WR_n, done} per cycle for back-to-back read then write.
    a0_pat = '{5'b10110, 5'b11010, 5'b11111, 5'b01110, 5'b10110, 5'b11100, 5'b11111};

    if0.req_i = 0; if0.we_i = 0; if0.addr_i = 0; if0.wdata_i = 0; if0.flags_i = 0;
    if0.D_i = 0; if0.hold_i = 0; if0.enin_i = 1;
    if3.req_i = 0; if3.we_i = 0; if3.addr_i = 0; if3.wdata_i = 0; if3.flags_i = 0;
    if3.D_i = 0; if3.hold_i = 0; if3.enin_i = 1;
    ifa.req_i = 0; ifa.we_i = 0; ifa.addr_i = 0; ifa.wdata_i = 0; ifa.flags_i = 0;
    ifa.D_i = 0; ifa.hold_i = 0; ifa.enin_i = 1;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_strobes", {if0.ADS_n, if0.RD_n, if0.WR_n}, 3'b111);
    chk("rst_ctl", {if0.breq_o, if0.done_o, if0.busy_o, if0.D_oe_o}, 4'b0000);
    chk("rst_do", if0.D_o, 8'h00);
    chk("rst_addr_o", if0.addr_o, 12'h000);
    chk("rst_rdata", if0.rdata_o, 8'h00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Basic read/write vectors
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Grant withheld for 5 cycles
    if0.enin_i = 1'b0; if0.we_i = 1'b0; if0.addr_i = 16'h2222; if0.flags_i = 4'h0;
    if0.D_i = 8'h3E; if0.req_i = 1'b1;
    step(); if0.req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("arbw_breq", if0.breq_o, 1'b1);
      chk("arbw_ads", if0.ADS_n, 1'b1);
      chk("arbw_enout", if0.enout_o, 1'b0);
      chk("arbw_busy", if0.busy_o, 1'b1);
      if (i == 4) if0.enin_i = 1'b1;
      step();
    end
    chk("arbw_ads_after", if0.ADS_n, 1'b0);
    chk("arbw_enout_after", if0.enout_o, 1'b0);
    step();
    chk("arbw_rd", if0.RD_n, 1'b0);
    step();
    chk("arbw_done", if0.done_o, 1'b1);
    chk("arbw_rdata", if0.rdata_o, 8'h3E);
    step();

    // Hold extends the strobe; data taken only on the exit edge
    if0.we_i = 1'b0; if0.addr_i = 16'h3333; if0.hold_i = 1'b1; if0.D_i = 8'h11;
    if0.req_i = 1'b1;
    step(); if0.req_i = 1'b0;
    step();
    cnt = 0;
    for (int i = 0; i < 20 && !if0.done_o; i++) begin
      step();
      if (!if0.RD_n) begin
        cnt++;
        if (cnt < 4) chk("hold_rdata_held", if0.rdata_o, 8'h3E);
        if (cnt == 4) begin
          if0.hold_i = 1'b0;
          if0.D_i = 8'h99;
        end
      end
    end
    chk("hold_rd_len", cnt[15:0], 16'd4);
    chk("hold_done", if0.done_o, 1'b1);
    chk("hold_rdata", if0.rdata_o, 8'h99);
    step();

    // Write with WAIT_CYCLES=3
    if3.we_i = 1'b1; if3.addr_i = 16'h1234; if3.flags_i = 4'b0100; if3.wdata_i = 8'hC3;
    if3.req_i = 1'b1;
    step(); if3.req_i = 1'b0;
    step();
    chk("w3_ads", if3.ADS_n, 1'b0);
    chk("w3_ado", if3.D_o, 8'h41);
    cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!if3.WR_n) begin
        cnt++;
        chk("w3_do", if3.D_o, 8'hC3);
        chk("w3_oe", if3.D_oe_o, 1'b1);
      end
      if (if3.done_o) done_cnt++;
    end
    chk("w3_wr_len", cnt[15:0], 16'd4);
    chk("w3_done_pulses", done_cnt[15:0], 16'd1);

    // Reset in the middle of a write strobe
    if3.wdata_i = 8'h5D; if3.req_i = 1'b1;
    step(); if3.req_i = 1'b0;
    step();
    step();
    chk("rstw_wr_before", if3.WR_n, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("rstw_wr", if3.WR_n, 1'b1);
    chk("rstw_oe", if3.D_oe_o, 1'b0);
    chk("rstw_busy", if3.busy_o, 1'b0);
    chk("rstw_do", if3.D_o, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    if3.we_i = 1'b0; if3.addr_i = 16'h0ABC; if3.flags_i = 4'b0010; if3.D_i = 8'h6E;
    if3.req_i = 1'b1;
    step(); if3.req_i = 1'b0;
    k = 0;
    while (!if3.done_o && k < 20) begin
      step();
      k++;
    end
    chk("rstw_latency", k[15:0], 16'd6);
    chk("rstw_rdata", if3.rdata_o, 8'h6E);
    chk("rstw_addr_o", if3.addr_o, 12'hABC);
    step();

    // ARB_EN=0, back-to-back read then write with req held high
    ifa.we_i = 1'b0; ifa.addr_i = 16'h0456; ifa.flags_i = 4'h0; ifa.D_i = 8'h42;
    ifa.req_i = 1'b1;
    step();
    ifa.we_i = 1'b1; ifa.addr_i = 16'h0789; ifa.wdata_i = 8'h9C;
    for (int i = 0; i < 7; i++) begin
      chk("a0_pat", {ifa.busy_o, ifa.ADS_n, ifa.RD_n, ifa.WR_n, ifa.done_o}, a0_pat[i]);
      chk("a0_breq", ifa.breq_o, 1'b0);
      if (i == 0) chk("a0_addr1", ifa.addr_o, 12'h456);
      if (i == 2) chk("a0_rdata", ifa.rdata_o, 8'h42);
      if (i == 4) begin
        chk("a0_addr2", ifa.addr_o, 12'h789);
        ifa.req_i = 1'b0;
      end
      if (i == 5) chk("a0_wdata", ifa.D_o, 8'h9C);
      step();
    end
    chk("a0_idle", ifa.busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scmp_busif.md
SCMP_BUSIF -- requirements
Module: scmp_busif

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, range 0..15: extra read/write strobe cycles per bus cycle.
REQ-002 Parameter ARB_EN, default 1: 1 = bus arbitration enabled (BREQ/ENIN daisy chain), 0 = bus owned permanently.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  1  core requests a bus cycle; sampled in IDLE only.
REQ-006 we_i  input  1  1 = write cycle, 0 = read cycle; sampled with req_i.
REQ-007 addr_i  input  16  full cycle address; sampled with req_i.
REQ-008 wdata_i  input  8  write data; sampled with req_i.
REQ-009 flags_i  input  4  cycle-type flags {H,D,I,R}; sampled with req_i.
REQ-010 busy_o  output  1  high in every state other than IDLE.
REQ-011 done_o  output  1  one-cycle pulse, cycle complete.
REQ-012 rdata_o  output  8  read data, held until the next read completes.
REQ-013 addr_o  output  12  external address pins = latched address[11:0].
REQ-014 D_i / D_o / D_oe_o  input/output/output  8/8/1  external data bus in, out, output enable.
REQ-015 ADS_n / RD_n / WR_n  output  1 each  active-low address, read and write strobes.
REQ-016 hold_i  input  1  external hold; extends the strobe phase while high.
REQ-017 breq_o / enin_i / enout_o  output/input/output  1 each  bus request, bus grant in, grant chain out.

Function
REQ-018 States: IDLE, ARB, ADDR, STROBE, RECOVER.
REQ-019 IDLE: if req_i=1, latch we/addr/wdata/flags; next state ARB if ARB_EN=1, else ADDR.
REQ-020 ARB: breq_o=1; advance to ADDR on the first edge with enin_i=1; otherwise remain in ARB indefinitely.
REQ-021 breq_o stays high from ARB through RECOVER; losing enin_i after ARB does not abort the cycle.
REQ-022 ADDR: exactly one cycle; ADS_n=0, D_oe_o=1, D_o={H,D,I,R,addr[15:12]}; load wait counter with WAIT_CYCLES.
REQ-023 STROBE: RD_n=0 (read) or WR_n=0 (write); on write D_oe_o=1 and D_o=wdata.
REQ-024 STROBE decrements the counter each cycle while it is nonzero.
REQ-025 STROBE exits to RECOVER on the first edge where counter=0 and hold_i=0; minimum length 1+WAIT_CYCLES cycles.
REQ-026 Read data: rdata_o captures D_i on the STROBE exit edge only.
REQ-027 RECOVER: one cycle; all strobes high, D_oe_o=0, done_o=1; next state IDLE.
REQ-028 Latency: with ARB_EN=1, enin_i=1 and WAIT_CYCLES=0, req accepted at edge N, done_o high in cycle N+4; ARB_EN=0 removes one cycle.
REQ-029 addr_o is updated at acceptance and held stable through RECOVER.
REQ-030 req_i is ignored outside IDLE; back-to-back cycles accepted the cycle after RECOVER.
REQ-031 enout_o = enin_i AND NOT breq_o (combinational).
REQ-032 Outside ADDR and write-STROBE, D_o=8'h00 and D_oe_o=0.
REQ-033 Strobes are registered outputs, glitch-free; at most one of ADS_n, RD_n, WR_n low in any cycle.

Reset
REQ-034 rst_n low forces IDLE immediately, including mid-cycle.
REQ-035 Reset values: ADS_n=RD_n=WR_n=1, breq_o=0, done_o=0, busy_o=0, D_oe_o=0, D_o=0, addr_o=0, rdata_o=0, wait counter=0.

Structure
REQ-036 Package scmp_busif_pak holds the state enum typedef and the flag bit indices (FLAG_H/D/I/R); the core shares these indices.
REQ-037 Single module, no sub-module; the wait counter is 4 bits.

Verification
REQ-038 Read, WAIT_CYCLES=0, ARB_EN=1, enin_i=1, addr_i=16'hA123, flags 4'b0001, D_i=8'h5A -> ADS_n low with D_o=8'h1A, addr_o=12'h123, RD_n low 1 cycle, rdata_o=8'h5A, done_o at N+4.
REQ-039 Write, WAIT_CYCLES=3, wdata_i=8'hC3 -> WR_n low exactly 4 cycles, D_o=8'hC3 with D_oe_o=1 throughout, done_o one pulse.
REQ-040 Read, enin_i held 0 for 5 cycles then 1 -> breq_o high, ADS_n high during wait, enout_o=0, cycle proceeds after grant.
REQ-041 hold_i high for 3 cycles during STROBE, WAIT_CYCLES=0 -> RD_n low 4 cycles, D_i captured only on exit edge.
REQ-042 rst_n asserted mid-STROBE write -> WR_n=1, D_oe_o=0, busy_o=0 asynchronously; first request after reset completes normally.
REQ-043 ARB_EN=0, two back-to-back requests -> each completes in 3 cycles, breq_o never high, second accepted the cycle after first RECOVER.
